// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, per-frame
// scan result, code widths and column-decoding helpers.
package keypad_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int CODE_W = ROW_W + COL_W;

    typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;
    typedef enum logic [1:0] {NONE, KEY, MULTI} res_t;

    typedef struct packed {
        res_t              res;
        logic [CODE_W-1:0] code;
    } frame_t;

    // Number of active columns in one row sample, saturated at 2 (2 means "many").
    function automatic logic [1:0] low_count(input logic [COLS-1:0] low);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < COLS; i++)
            if (low[i]) n = (n == 2'd2) ? 2'd2 : n + 2'd1;
        return n;
    endfunction

    function automatic logic [COL_W-1:0] low_index(input logic [COLS-1:0] low);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--)
            if (low[i]) idx = COL_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-event bus: the scanner drives rows and events,
// the panel/consumer side drives the columns.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [COLS-1:0]   col_n;
    logic [ROWS-1:0]   row_n;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_down;

    modport master (input col_n, output row_n, key_valid, key_code, key_down);
    modport slave  (output col_n, input row_n, key_valid, key_code, key_down);

endinterface

// File: rtl/keypad_scanner_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a slow strobe that is
// sampled as data; rise is one clk cycle wide.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], din};
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with frame-level debounce and one event per press.
// Optional held-key auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEB_FRAMES    = 8,
    parameter int REPEAT_FRAMES = 384
) (
    input  logic              OCLK,
    input  logic              rst,
    input  logic              ICLK,
    keypad_scanner_if.master  bus
);

    localparam int                CNT_W   = $clog2(DEB_FRAMES + 1);
    localparam logic [CNT_W-1:0]  DEB_LIM = CNT_W'(DEB_FRAMES);

    logic scan_tick;

    edge_sync u_iclk_sync (
        .clk  (OCLK),
        .rst  (rst),
        .din  (ICLK),
        .rise (scan_tick)
    );

    logic [COLS-1:0] col_s1, col_s2;

    always_ff @(posedge OCLK) begin
        if (rst) begin
            col_s1 <= '0;
            col_s2 <= '0;
        end else begin
            col_s1 <= bus.col_n;
            col_s2 <= col_s1;
        end
    end

    // Row scan and frame accumulation: hits saturates at 2 (MULTI).
    logic [ROW_W-1:0]  row_q;
    logic [1:0]        acc_hits_q;
    logic [CODE_W-1:0] acc_code_q;
    logic [COLS-1:0]   low;
    logic [1:0]        row_hits;
    logic [2:0]        sum;
    logic [1:0]        hits;
    logic [CODE_W-1:0] code_now;
    logic              frame_end;
    frame_t            frame;

    assign low = ~col_s2;

    always_comb begin
        row_hits  = low_count(low);
        sum       = {1'b0, acc_hits_q} + {1'b0, row_hits};
        hits      = (sum > 3'd2) ? 2'd2 : sum[1:0];
        code_now  = (acc_hits_q == 2'd0) ? {row_q, low_index(low)} : acc_code_q;
        frame_end = scan_tick && (row_q == ROW_W'(ROWS - 1));
        frame.code = code_now;
        case (hits)
            2'd0:    frame.res = NONE;
            2'd1:    frame.res = KEY;
            default: frame.res = MULTI;
        endcase
    end

    always_ff @(posedge OCLK) begin
        if (rst) begin
            row_q      <= '0;
            acc_hits_q <= '0;
            acc_code_q <= '0;
        end else if (scan_tick) begin
            row_q <= row_q + ROW_W'(1);
            if (frame_end) begin
                acc_hits_q <= '0;
                acc_code_q <= '0;
            end else begin
                acc_hits_q <= hits;
                acc_code_q <= code_now;
            end
        end
    end

    assign bus.row_n = ~(ROWS'(1) << row_q);

    // Debounce FSM, stepped only at frame end.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, rel_q, rel_d, cnt_inc, rel_inc;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] code_q;
    logic              down_q, valid_q;
    logic              accept, drop, held_match, rep_fire;

    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign rel_inc    = (rel_q == '1) ? rel_q : rel_q + CNT_W'(1);
    assign held_match = (frame.res == KEY) && (frame.code == code_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        drop    = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame.res == KEY) begin
                        cand_d = frame.code;
                        if (DEB_FRAMES == 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                            rel_d   = '0;
                        end else begin
                            state_d = DEB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEB: begin
                    if (frame.res == KEY && frame.code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_LIM) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                            rel_d   = '0;
                        end
                    end else if (frame.res == KEY) begin
                        cand_d = frame.code;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (held_match) begin
                        rel_d = '0;
                    end else begin
                        rel_d = rel_inc;
                        if (rel_inc >= DEB_LIM) begin
                            drop    = 1'b1;
                            state_d = IDLE;
                            rel_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W   = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LIM = REP_W'(REPEAT_FRAMES);

    logic [REP_W-1:0] rep_q, rep_d;

    // Counts matching held frames since accept or the last repeat.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (state_q != HELD) begin
            rep_d = '0;
        end else if (frame_end) begin
            if (!held_match) begin
                rep_d = '0;
            end else if (rep_q + REP_W'(1) >= REP_LIM) begin
                rep_fire = 1'b1;
                rep_d    = '0;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge OCLK) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge OCLK) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rel_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            down_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            cand_q  <= cand_d;
            valid_q <= accept | rep_fire;
            if (accept) begin
                code_q <= cand_d;
                down_q <= 1'b1;
            end else if (drop) begin
                down_q <= 1'b0;
            end
        end
    end

    assign bus.key_valid = valid_q;
    assign bus.key_code  = code_q;
    assign bus.key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed table-driven bench for keypad_scanner with a behavioural key matrix.
module tb_keypad_scanner;

    logic        OCLK = 1'b0;
    logic        rst  = 1'b1;
    logic        ICLK = 1'b0;
    logic [15:0] keys = 16'h0000;
    int          n_cmp = 0;
    int          n_err = 0;
    int          vcnt  = 0;

    keypad_scanner_if bus ();

    keypad_scanner #(.DEB_FRAMES(8), .REPEAT_FRAMES(4)) dut (
        .OCLK (OCLK),
        .rst  (rst),
        .ICLK (ICLK),
        .bus  (bus.master)
    );

    always #5 OCLK = ~OCLK;

    always begin
        repeat (4) @(negedge OCLK);
        ICLK = ~ICLK;
    end

    // Pressed key at (r,c) pulls column c low while row r is driven.
    always_comb begin
        bus.col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!bus.row_n[r] && keys[r*4+c]) bus.col_n[c] = 1'b0;
    end

    always @(negedge OCLK) if (bus.key_valid === 1'b1) vcnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame();
        logic [3:0] prev;
        int k;
        prev = bus.row_n;
        k = 0;
        forever begin
            @(negedge OCLK);
            k++;
            if (prev == 4'b0111 && bus.row_n == 4'b1110) break;
            if (k > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL frame_timeout: got no frame end expected one within 200 cycles");
                break;
            end
            prev = bus.row_n;
        end
        repeat (2) @(negedge OCLK);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) wait_frame();
    endtask

    typedef struct {
        logic [15:0] keys;
        int          nfr;
        int          exp_cnt;
        logic [3:0]  exp_code;
        logic        exp_down;
    } vec_t;

    vec_t       tbl[17];
    logic [3:0] rseq[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h0000,            2, 0, 4'd0,  1'b0};
        tbl[1]  = '{16'h0001 << 9,       7, 0, 4'd0,  1'b0};
        tbl[2]  = '{16'h0001 << 9,       1, 1, 4'd9,  1'b1};
        tbl[3]  = '{16'h0001 << 9,       3, 1, 4'd9,  1'b1};
        tbl[4]  = '{16'h0000,            7, 1, 4'd9,  1'b1};
        tbl[5]  = '{16'h0000,            1, 1, 4'd9,  1'b0};
        tbl[6]  = '{16'h0001 << 5,       3, 1, 4'd9,  1'b0};
        tbl[7]  = '{16'h0000,            1, 1, 4'd9,  1'b0};
        tbl[8]  = '{16'h0001 << 5,       7, 1, 4'd9,  1'b0};
        tbl[9]  = '{16'h0001 << 5,       1, 2, 4'd5,  1'b1};
        tbl[10] = '{16'h0000,            8, 2, 4'd5,  1'b0};
        tbl[11] = '{16'h8001,           10, 2, 4'd5,  1'b0};
        tbl[12] = '{16'h00C0,            9, 2, 4'd5,  1'b0};
        tbl[13] = '{16'h8000,            8, 3, 4'd15, 1'b1};
        tbl[14] = '{16'h0001 << 10,      8, 3, 4'd15, 1'b0};
        tbl[15] = '{16'h0001 << 10,      8, 4, 4'd10, 1'b1};
        tbl[16] = '{16'h0000,            8, 4, 4'd10, 1'b0};
        rseq[0] = 4'b1101; rseq[1] = 4'b1011; rseq[2] = 4'b0111; rseq[3] = 4'b1110;

        repeat (10) @(negedge OCLK);
        chk("reset_row_n", 32'(bus.row_n), 32'h0000000E);
        chk("reset_valid", 32'(bus.key_valid), 0);
        chk("reset_code", 32'(bus.key_code), 0);
        chk("reset_down", 32'(bus.key_down), 0);
        rst = 1'b0;

        // Row drive rotation with nothing pressed.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] prev;
            int k;
            prev = bus.row_n;
            k = 0;
            while (bus.row_n == prev && k < 50) begin
                @(negedge OCLK);
                k++;
            end
            chk($sformatf("row_seq%0d", i), 32'(bus.row_n), 32'(rseq[i]));
        end

        for (int i = 0; i < 17; i++) begin
            keys = tbl[i].keys;
            frames(tbl[i].nfr);
            chk($sformatf("v%0d_count", i), 32'(vcnt), 32'(tbl[i].exp_cnt));
            chk($sformatf("v%0d_code", i), 32'(bus.key_code), 32'(tbl[i].exp_code));
            chk($sformatf("v%0d_down", i), 32'(bus.key_down), 32'(tbl[i].exp_down));
        end

        // Reset in the middle of debounce discards the candidate.
        keys = 16'h0001 << 6;
        frames(6);
        rst = 1'b1;
        @(negedge OCLK);
        chk("rst_row_n", 32'(bus.row_n), 32'h0000000E);
        chk("rst_valid", 32'(bus.key_valid), 0);
        chk("rst_code", 32'(bus.key_code), 0);
        chk("rst_down", 32'(bus.key_down), 0);
        rst = 1'b0;
        frames(2);
        chk("rst_no_event", 32'(vcnt), 4);
        frames(6);
        chk("rst_reaccept_count", 32'(vcnt), 5);
        chk("rst_reaccept_code", 32'(bus.key_code), 6);
        keys = 16'h0000;
        frames(8);
        chk("rst_release_down", 32'(bus.key_down), 0);

        // Long hold of key 3: single event, or auto-repeat every 4 frames.
        keys = 16'h0008;
        frames(8);
        chk("hold3_accept_count", 32'(vcnt), 6);
        chk("hold3_code", 32'(bus.key_code), 3);
        frames(20);
`ifdef KEYPAD_REPEAT_EN
        chk("hold3_repeat_count", 32'(vcnt), 11);
`else
        chk("hold3_repeat_count", 32'(vcnt), 6);
`endif
        chk("hold3_code_held", 32'(bus.key_code), 3);
        chk("hold3_down", 32'(bus.key_down), 1);
        keys = 16'h0000;
        frames(8);
        chk("hold3_release_down", 32'(bus.key_down), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
